// File: rtl/sweep_ctrl_if.sv
// Bus bundle for sweep_ctrl: run controls, sweep programming, counter
// feedback/controls and status. Optional sweep_num appears only when
// SWEEP_CTRL_STATUS_EN is defined.
//
// Control semantics: start is a one-cycle request that is honoured only
// while the block is idle (busy=0) and stop is low; there is no ready
// signal, so a start seen while busy is simply dropped. stop is a level
// that wins over start, kills cnt_en in the same cycle and returns the
// block to IDLE on the next edge.
interface sweep_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int PRE_W   = 8,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   lo_lim;
    logic [WIDTH-1:0]   hi_lim;
    logic [PRE_W-1:0]   prescale;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         cycles;
    logic [WIDTH-1:0]   count;
    logic               cnt_en;
    logic               cnt_up;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         phase;
`ifdef SWEEP_CTRL_STATUS_EN
    logic [3:0]         sweep_num;

    modport master (
        output start, stop, lo_lim, hi_lim, prescale, dwell, cycles, count,
        input  cnt_en, cnt_up, busy, done, err, phase, sweep_num
    );
    modport slave (
        input  start, stop, lo_lim, hi_lim, prescale, dwell, cycles, count,
        output cnt_en, cnt_up, busy, done, err, phase, sweep_num
    );
`else
    modport master (
        output start, stop, lo_lim, hi_lim, prescale, dwell, cycles, count,
        input  cnt_en, cnt_up, busy, done, err, phase
    );
    modport slave (
        input  start, stop, lo_lim, hi_lim, prescale, dwell, cycles, count,
        output cnt_en, cnt_up, busy, done, err, phase
    );
`endif
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives an external up/down counter so its value sweeps as a
// triangle wave between latched low/high limits, with a step prescaler and
// a dwell at each limit. Runs a programmed number of sweeps (0=forever).
// Optional macro SWEEP_CTRL_STATUS_EN exposes the sweep counter as sweep_num.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRE_W   = 8,
    parameter int DWELL_W = 8
) (
    input logic       clk,
    input logic       reset,
    sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEEK    = 3'd1,
        UP      = 3'd2,
        HOLD_HI = 3'd3,
        DOWN    = 3'd4,
        HOLD_LO = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [PRE_W-1:0]   pre_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         cyc_q;

    logic [PRE_W-1:0]   pre_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [3:0]         sweep_cnt;
    logic [3:0]         sweep_inc;
    logic               up_q;
    logic               err_q;

    logic               moving;
    logic               holding;
    logic [WIDTH-1:0]   target;
    logic               at_target;
    logic               tick;
    logic               dwell_end;
    logic               start_seen;
    logic               start_ok;
    logic               start_bad;
    logic               cnt_up_c;

    // Shared decode: which limit is being chased, prescaler tick, dwell end.
    always_comb begin
        moving     = (state == SEEK) || (state == UP) || (state == DOWN);
        holding    = (state == HOLD_HI) || (state == HOLD_LO);
        target     = (state == UP) ? hi_q : lo_q;
        at_target  = (bus.count == target);
        tick       = (pre_cnt == pre_q);
        dwell_end  = (dwell_cnt == dwell_q);
        sweep_inc  = sweep_cnt + 4'd1;
        start_seen = (state == IDLE) && bus.start && !bus.stop;
        start_ok   = start_seen && (bus.lo_lim < bus.hi_lim);
        start_bad  = start_seen && !(bus.lo_lim < bus.hi_lim);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_next = state;
        if (bus.stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok)  state_next = SEEK;
                SEEK:    if (at_target) state_next = UP;
                UP:      if (at_target) state_next = HOLD_HI;
                HOLD_HI: if (dwell_end) state_next = DOWN;
                DOWN:    if (at_target) state_next = HOLD_LO;
                HOLD_LO: begin
                    if (dwell_end) begin
                        if ((cyc_q != 4'd0) && (sweep_inc == cyc_q)) state_next = DONE;
                        else                                         state_next = UP;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs; cnt_en only on a tick that still has distance to cover, so
    // the counter lands exactly on the limit.
    always_comb begin
        cnt_up_c = up_q;
        case (state)
            SEEK:    cnt_up_c = (bus.count < lo_q);
            UP:      cnt_up_c = 1'b1;
            DOWN:    cnt_up_c = 1'b0;
            default: cnt_up_c = up_q;
        endcase
        bus.cnt_en = moving && tick && !at_target && !bus.stop;
        bus.cnt_up = cnt_up_c;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        bus.err    = err_q;
        bus.phase  = state;
    end

    // Run parameters are captured on any start taken in IDLE, so later
    // input changes cannot disturb a run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            pre_q   <= '0;
            dwell_q <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            if (start_seen) begin
                lo_q    <= bus.lo_lim;
                hi_q    <= bus.hi_lim;
                pre_q   <= bus.prescale;
                dwell_q <= bus.dwell;
                cyc_q   <= bus.cycles;
            end
            err_q <= start_bad;
            up_q  <= cnt_up_c;
        end
    end

    // Prescale and dwell counters restart whenever the state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= '0;
            dwell_cnt <= '0;
        end else if (state_next != state) begin
            pre_cnt   <= '0;
            dwell_cnt <= '0;
        end else begin
            if (moving)  pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
            if (holding) dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Completed-sweep counter; wraps freely in continuous mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt <= 4'd0;
        end else if (start_ok) begin
            sweep_cnt <= 4'd0;
        end else if ((state == HOLD_LO) && dwell_end && !bus.stop) begin
            sweep_cnt <= sweep_inc;
        end
    end

`ifdef SWEEP_CTRL_STATUS_EN
    assign bus.sweep_num = sweep_cnt;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl. An up/down counter model closes the feedback loop;
// expected per-cycle traces are built from segment lengths (steps times
// prescale period, dwell+1 holds) and compared cycle by cycle.
module tb_sweep_ctrl;

    localparam logic [2:0] P_IDLE = 3'd0, P_SEEK = 3'd1, P_UP = 3'd2,
                           P_HHI = 3'd3, P_DOWN = 3'd4, P_HLO = 3'd5, P_DONE = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_val;

    int checks   = 0;
    int failures = 0;

    // Trace entry: {err, done, busy, en&up, en, phase[2:0], count[7:0]}
    logic [15:0] exp_q[$];

    sweep_ctrl_if #(.WIDTH(8), .PRE_W(8), .DWELL_W(8)) bus ();

    sweep_ctrl #(.WIDTH(8), .PRE_W(8), .DWELL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // External counter driven by the DUT's controls.
    always @(posedge clk) begin
        if (load)            bus.count <= load_val;
        else if (bus.cnt_en) bus.count <= bus.cnt_up ? bus.count + 8'd1 : bus.count - 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_obs();
        return 32'({bus.err, bus.done, bus.busy, bus.cnt_en & bus.cnt_up,
                    bus.cnt_en, bus.phase, bus.count});
    endfunction

    function automatic logic [15:0] mk(input logic er, input logic dn, input logic bs,
                                       input logic up, input logic en,
                                       input logic [2:0] ph, input int c);
        return {er, dn, bs, up, en, ph, c[7:0]};
    endfunction

    // Reference model: move toward tgt one step per (p+1) cycles, then one
    // cycle sitting on the limit before the phase changes.
    task automatic push_move(input logic [2:0] ph, inout int c, input int tgt,
                             input int p, input logic up);
        while (c != tgt) begin
            for (int i = 0; i < p; i++) exp_q.push_back(mk(0, 0, 1, 0, 0, ph, c));
            exp_q.push_back(mk(0, 0, 1, up, 1, ph, c));
            c = up ? c + 1 : c - 1;
        end
        exp_q.push_back(mk(0, 0, 1, 0, 0, ph, c));
    endtask

    task automatic push_hold(input logic [2:0] ph, input int d, input int c);
        for (int i = 0; i <= d; i++) exp_q.push_back(mk(0, 0, 1, 0, 0, ph, c));
    endtask

    task automatic gen_run(input int c0, input int lo, input int hi, input int p,
                           input int d, input int cyc, input int nsweeps);
        int c;
        c = c0;
        exp_q.delete();
        push_move(P_SEEK, c, lo, p, c0 < lo);
        for (int s = 0; s < nsweeps; s++) begin
            push_move(P_UP, c, hi, p, 1'b1);
            push_hold(P_HHI, d, c);
            push_move(P_DOWN, c, lo, p, 1'b0);
            push_hold(P_HLO, d, c);
        end
        if (cyc != 0) begin
            exp_q.push_back(mk(0, 1, 1, 0, 0, P_DONE, c));
            exp_q.push_back(mk(0, 0, 0, 0, 0, P_IDLE, c));
        end
    endtask

    task automatic scramble();
        bus.lo_lim   = 8'($urandom_range(0, 255));
        bus.hi_lim   = 8'($urandom_range(0, 255));
        bus.prescale = 8'($urandom_range(0, 255));
        bus.dwell    = 8'($urandom_range(0, 255));
        bus.cycles   = 4'($urandom_range(0, 15));
    endtask

    // Driver: load the counter, pulse start, then walk the expected trace,
    // optionally asserting stop at index stop_at and random ignored starts.
    task automatic run_trace(input int c0, input int lo, input int hi, input int p,
                             input int d, input int cyc, input int stop_at,
                             input int exp_sweep);
        logic [15:0] e;
        logic        stopped;
        int          n;
        stopped = 1'b0;
        n = exp_q.size();
        @(negedge clk);
        load = 1'b1;
        load_val = 8'(c0);
        @(negedge clk);
        load = 1'b0;
        bus.lo_lim   = 8'(lo);
        bus.hi_lim   = 8'(hi);
        bus.prescale = 8'(p);
        bus.dwell    = 8'(d);
        bus.cycles   = 4'(cyc);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        for (int idx = 0; idx < n; idx++) begin
            if (idx > 0) @(negedge clk);
            e = exp_q[idx];
            bus.stop  = (idx == stop_at);
            bus.start = (e[10:8] != P_IDLE) && (idx != stop_at) && ($urandom_range(0, 15) == 0);
            if (bus.start) scramble();
            #1;
            if (bus.stop) begin
                e[12] = 1'b0;
                e[11] = 1'b0;
            end
            check($sformatf("trace[%0d]", idx), pack_obs(), 32'(e));
            if (bus.stop) begin
                stopped = 1'b1;
                break;
            end
        end
        if (stopped) begin
            @(negedge clk);
            bus.stop  = 1'b0;
            bus.start = 1'b0;
            #1;
            check("stop_idle", pack_obs(), 32'(mk(0, 0, 0, 0, 0, P_IDLE, int'(e[7:0]))));
        end
        bus.start = 1'b0;
`ifdef SWEEP_CTRL_STATUS_EN
        check("sweep_num", 32'(bus.sweep_num), 32'(exp_sweep % 16));
`else
        if (exp_sweep < 0) $display("note: negative sweep expectation");
`endif
    endtask

    // Watchdog: the run should never get near this bound.
    initial begin
        #800000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lo, hi, c0, p, d, cyc, first_up, stop_at;
        reset = 1'b1;
        load = 1'b1;
        load_val = 8'd0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.lo_lim = 8'd0;
        bus.hi_lim = 8'd0;
        bus.prescale = 8'd0;
        bus.dwell = 8'd0;
        bus.cycles = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        load = 1'b0;
        #1;
        check("reset_state", pack_obs(), 32'(mk(0, 0, 0, 0, 0, P_IDLE, 0)));

        // Directed sweep 0 -> 3..6, dwell 1, one sweep.
        gen_run(0, 3, 6, 0, 1, 1, 1);
        run_trace(0, 3, 6, 0, 1, 1, -1, 1);

        // Seek downward from above the window.
        gen_run(200, 10, 20, 0, 0, 1, 1);
        run_trace(200, 10, 20, 0, 0, 1, -1, 1);

        // Prescale 3 with the lower limit at zero.
        gen_run(0, 0, 2, 3, 0, 2, 2);
        run_trace(0, 0, 2, 3, 0, 2, -1, 2);

        // Upper limit at the top of the range.
        gen_run(245, 250, 255, 1, 2, 1, 1);
        run_trace(245, 250, 255, 1, 2, 1, -1, 1);

        // Rejected start: equal limits, then inverted limits.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.lo_lim = 8'd5 + 8'(k);
            bus.hi_lim = 8'd5;
            bus.start  = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check("err_pulse", 32'({bus.err, bus.busy, bus.phase}), 32'({1'b1, 1'b0, P_IDLE}));
            @(negedge clk);
            #1;
            check("err_clear", 32'({bus.err, bus.busy, bus.phase}), 32'({1'b0, 1'b0, P_IDLE}));
        end

        // stop and start together: stop wins.
        @(negedge clk);
        bus.lo_lim = 8'd1;
        bus.hi_lim = 8'd9;
        bus.start  = 1'b1;
        bus.stop   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #1;
        check("stop_over_start", 32'({bus.err, bus.busy, bus.phase}), 32'({1'b0, 1'b0, P_IDLE}));

        // Randomised full runs.
        for (int r = 0; r < 6; r++) begin
            lo  = $urandom_range(0, 249);
            hi  = lo + $urandom_range(1, 5);
            c0  = $urandom_range(0, 255);
            p   = $urandom_range(0, 2);
            d   = $urandom_range(0, 3);
            cyc = $urandom_range(1, 3);
            gen_run(c0, lo, hi, p, d, cyc, cyc);
            run_trace(c0, lo, hi, p, d, cyc, -1, cyc);
        end

        // Randomised stop somewhere inside the first UP phase.
        for (int r = 0; r < 3; r++) begin
            lo  = $urandom_range(0, 249);
            hi  = lo + $urandom_range(1, 5);
            c0  = $urandom_range(0, 255);
            p   = $urandom_range(0, 2);
            d   = $urandom_range(0, 3);
            gen_run(c0, lo, hi, p, d, 1, 1);
            first_up = 0;
            while (exp_q[first_up][10:8] != P_UP) first_up++;
            stop_at = first_up + $urandom_range(0, (hi - lo) * (p + 1));
            run_trace(c0, lo, hi, p, d, 1, stop_at, 0);
        end

        // Continuous mode: 40 sweeps, then stop at the start of the 41st.
        begin
            int c;
            p = $urandom_range(0, 1);
            d = $urandom_range(0, 2);
            gen_run(1, 1, 2, p, d, 0, 40);
            stop_at = exp_q.size();
            c = 1;
            push_move(P_UP, c, 2, p, 1'b1);
            run_trace(1, 1, 2, p, d, 0, stop_at, 40);
        end

        // Reset in the middle of a run.
        @(negedge clk);
        bus.lo_lim = 8'd20;
        bus.hi_lim = 8'd30;
        bus.prescale = 8'd0;
        bus.dwell = 8'd0;
        bus.cycles = 4'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset", 32'({bus.err, bus.done, bus.busy, bus.cnt_en, bus.phase}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
